// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed seven-segment display driver.
//
// Scans DIGITS digits one slot at a time. Each slot lasts SCAN_DIV clocks,
// and the digit enable stays off for the first BLANK_CYC clocks of the slot
// so the previous digit's segment pattern cannot ghost onto the next digit.
// Each digit shows one hex nibble as abcdefg plus a decimal point.
// Loads go into a shadow buffer. The shadow is copied to the active buffer
// only on the frame boundary, which is the edge where the digit index wraps
// back to 0.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (release is synchronous)
//   load_i     one-cycle strobe, captures value_i/dp_i/blank_i into the shadow
//   value_i    hex nibble per digit, digit k = bits [4k+3:4k]
//   dp_i       decimal point per digit
//   blank_i    1 = digit k dark (segments/dp off, enable still scanned)
//   bright_i   (SEVENSEG_DIM_EN only) 4-bit brightness, 15 = full duty
//   seg_o      segments, bit6 = a ... bit0 = g (inverted when SEG_INV=1)
//   dp_o       decimal point (inverted when SEG_INV=1)
//   dig_o      one-hot digit enable (inverted when DIG_INV=1)
//   frame_o    one-cycle pulse while idx==0 and cnt==0 are first visible
//   pending_o  shadow holds data that has not been committed yet
//
// Optional feature macro: SEVENSEG_DIM_EN adds PWM dimming of the digit
// enable through bright_i. When the macro is undefined the display runs at
// full duty and there is no bright_i port.
//
// Output timing: every output is registered from (cnt, idx, active buffer),
// so the display lags the scan state by one clock. frame_o is registered
// from the frame-wrap condition, so it lines up with the internal state.

module sevenseg_scan #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int SEG_INV   = 0,
    parameter int DIG_INV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]            bright_i,
`endif
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     dig_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic SEG_POL = (SEG_INV != 0);
    localparam logic DIG_POL = (DIG_INV != 0);

    // Scan state
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                pending;

    // Double buffer: shadow is written by loads, active drives the display
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [4*DIGITS-1:0] act_val;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blank;

    logic slot_wrap;
    logic frame_wrap;

    assign slot_wrap  = (cnt == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);

    // Prescaler, digit index, buffers and commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '1;
        end else begin
            if (slot_wrap) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // The commit reads the pre-edge shadow, so a load on the same
            // edge is held back for the next frame and keeps pending set.
            if (frame_wrap && pending) begin
                act_val   <= sh_val;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
            end

            if (load_i) begin
                sh_val   <= value_i;
                sh_dp    <= dp_i;
                sh_blank <= blank_i;
                pending  <= 1'b1;
            end else if (frame_wrap) begin
                pending  <= 1'b0;
            end
        end
    end

    // Anti-ghost window: the enable stays off during the first BLANK_CYC
    // cycles of every slot.
    logic in_window;
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_window = 1'b1;
        end else begin : g_blank
            assign in_window = (cnt >= CNT_W'(BLANK_CYC));
        end
    endgenerate

    logic duty_ok;
`ifdef SEVENSEG_DIM_EN
    logic [3:0] pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm + 4'd1;
        end
    end

    // bright_i=15 gives full duty; bright_i=0 gives 1/16 duty.
    assign duty_ok = (pwm <= bright_i);
`else
    assign duty_ok = 1'b1;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Select the current digit from the active buffer, all active-high
    logic [3:0]        cur_val;
    logic              cur_dp;
    logic              cur_blank;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [DIGITS-1:0] dig_next;

    always_comb begin
        cur_val   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        dig_next  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_val     = act_val[4*k +: 4];
                cur_dp      = act_dp[k];
                cur_blank   = act_blank[k];
                dig_next[k] = in_window && duty_ok;
            end
        end
        seg_next = cur_blank ? 7'd0 : hex_to_seg(cur_val);
        dp_next  = cur_dp && !cur_blank;
    end

    // Output register; polarity is applied only here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= {7{SEG_POL}};
            dp_o    <= SEG_POL;
            dig_o   <= {DIGITS{DIG_POL}};
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_next ^ {7{SEG_POL}};
            dp_o    <= dp_next ^ SEG_POL;
            dig_o   <= dig_next ^ {DIGITS{DIG_POL}};
            frame_o <= frame_wrap;
        end
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed and random stimulus for sevenseg_scan
// (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, SEG_INV=0, DIG_INV=1).
// The reference model works from the number of clock edges since reset
// release. Slot position is edges mod 8, digit is (edges / 8) mod 4, and a
// frame boundary falls on every 32nd edge. The model also keeps its own
// shadow/active buffers and pending flag.

module tb_sevenseg_scan;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  dig_o;
    logic        frame_o;
    logic        pending_o;
`ifdef SEVENSEG_DIM_EN
    logic [3:0]  bright_i;
`endif

    sevenseg_scan #(
        .DIGITS   (4),
        .SCAN_DIV (8),
        .BLANK_CYC(2),
        .SEG_INV  (0),
        .DIG_INV  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_i),
        .value_i  (value_i),
        .dp_i     (dp_i),
        .blank_i  (blank_i),
`ifdef SEVENSEG_DIM_EN
        .bright_i (bright_i),
`endif
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .dig_o    (dig_o),
        .frame_o  (frame_o),
        .pending_o(pending_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int total = 0;
    int bad   = 0;

    // Reference model state
    int          n;          // clock edges since reset release
    int          bright = 15;
    logic [15:0] m_sh_val, m_ac_val;
    logic [3:0]  m_sh_dp, m_ac_dp;
    logic [3:0]  m_sh_bl, m_ac_bl;
    logic        m_pend;

    logic [6:0] seg_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_sh_val = 16'h0;
        m_ac_val = 16'h0;
        m_sh_dp  = 4'h0;
        m_ac_dp  = 4'h0;
        m_sh_bl  = 4'hF;
        m_ac_bl  = 4'hF;
        m_pend   = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dig", 32'(dig_o), 32'hF);
        chk("rst_seg", 32'(seg_o), 32'h0);
        chk("rst_dp", 32'(dp_o), 32'h0);
        chk("rst_frame", 32'(frame_o), 32'h0);
        chk("rst_pending", 32'(pending_o), 32'h0);
    endtask

    // One clock edge: drive inputs, predict outputs, check them after the edge
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] b);
        int         s, slot_pos, dig_idx;
        logic [3:0] dig_m;
        logic [6:0] seg_m;
        logic       dp_m, frame_m, commit;
        load_i  = ld;
        value_i = v;
        dp_i    = d;
        blank_i = b;
        @(posedge clk);
        // The outputs after this edge show the state that held before it
        s        = n;
        slot_pos = s % 8;
        dig_idx  = (s / 8) % 4;
        dig_m    = 4'b0000;
        if (slot_pos >= 2 && (s % 16) <= bright) dig_m[dig_idx] = 1'b1;
        dig_m = ~dig_m;
        if (m_ac_bl[dig_idx]) begin
            seg_m = 7'd0;
            dp_m  = 1'b0;
        end else begin
            seg_m = seg_tbl[m_ac_val[4*dig_idx +: 4]];
            dp_m  = m_ac_dp[dig_idx];
        end
        n       = n + 1;
        commit  = (n % 32 == 0);
        frame_m = commit;
        if (commit && m_pend) begin
            m_ac_val = m_sh_val;
            m_ac_dp  = m_sh_dp;
            m_ac_bl  = m_sh_bl;
        end
        if (ld) begin
            m_sh_val = v;
            m_sh_dp  = d;
            m_sh_bl  = b;
            m_pend   = 1'b1;
        end else if (commit) begin
            m_pend = 1'b0;
        end
        #1;
        chk("dig", 32'(dig_o), 32'(dig_m));
        chk("seg", 32'(seg_o), 32'(seg_m));
        chk("dp", 32'(dp_o), 32'(dp_m));
        chk("frame", 32'(frame_o), 32'(frame_m));
        chk("pending", 32'(pending_o), 32'(m_pend));
        load_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        load_i  = 1'b0;
        value_i = 16'h0;
        dp_i    = 4'h0;
        blank_i = 4'h0;
`ifdef SEVENSEG_DIM_EN
        bright_i = 4'd15;
`endif
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: no load, blank digits, enable walk and frame pulses
        idle(70);

        // 2: load mid-frame, committed at the next frame boundary
        step(1'b1, 16'h8A31, 4'b0100, 4'b0000);
        idle(70);

        // 3: two loads in one frame, the last one wins
        while (n % 32 != 3) idle(1);
        step(1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(5);
        step(1'b1, 16'h2222, 4'b0000, 4'b0000);
        idle(70);

        // 4: load on the exact commit edge
        while (n % 32 != 10) idle(1);
        step(1'b1, 16'h4567, 4'b0011, 4'b0000);
        while ((n + 1) % 32 != 0) idle(1);
        step(1'b1, 16'hCDEF, 4'b1000, 4'b0010);
        idle(70);

        // 5: asynchronous reset mid-slot while digit 2 is enabled
        step(1'b1, 16'h9999, 4'b1111, 4'b0000);
        while (!((n / 8) % 4 == 2 && n % 8 == 5)) idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);

        // Random loads
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
            else
                idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
